dice_race_turn_ctrl: RTL

- Game-logic stage directly downstream of the intro/game starter; consumes its is_game, menu_select and game_start_tick outputs.
- Runs the dice-race turn loop: waits for a roll request, captures a stable die value from the OV7670 dice recognizer, and advances the current player one square at a time.
- Detects the winner and feeds positions and turn state to the VGA overlay renderer.

---
 rtl/dice_race_turn_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/dice_race_turn_ctrl.sv
// dice_race_turn_ctrl
// Turn sequencer for the dice-race game. It waits for a roll request,
// accepts a die value once it has stayed stable, walks the current player
// forward one square per STEP_CYCLES clocks, then checks for a winner and
// passes the turn to the next player.
//
// Optional feature macro: EXACT_FINISH_EN
//   defined   : the finish must be hit exactly; surplus steps bounce back.
//   undefined : the position clamps at TRACK_LEN and surplus pips are dropped.
//
// Ports
//   clk, reset       : system clock, synchronous active-high reset
//   is_game          : game screen active; low forces IDLE and clears the board
//   menu_select      : 0 = 2 players, 1 = 4 players (sampled leaving IDLE)
//   game_start_tick  : roll request level; its rising edge starts a capture
//   dice_valid       : dice_value carries a reading this cycle
//   dice_value       : recognised pips, 1..6 legal
//   cur_player       : player whose turn it is
//   pos_flat         : player k position at [k*POS_W +: POS_W]
//   roll_value       : last accepted die value
//   phase            : FSM state (IDLE=0 .. DONE=6), also the debug view
//   step_pulse       : one-cycle pulse per square moved
//   winner_valid     : high while in DONE
//   winner_id        : winning player, meaningful when winner_valid
//
// Interface semantics: dice_valid is a valid-only qualifier with no ready;
// the recogniser streams readings and this block samples them every cycle.
module dice_race_turn_ctrl #(
  parameter int TRACK_LEN   = 30,
  parameter int POS_W       = 5,
  parameter int STEP_CYCLES = 12_500_000,
  parameter int STABLE_CNT  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               is_game,
  input  logic               menu_select,
  input  logic               game_start_tick,
  input  logic               dice_valid,
  input  logic [2:0]         dice_value,
  output logic [1:0]         cur_player,
  output logic [4*POS_W-1:0] pos_flat,
  output logic [2:0]         roll_value,
  output logic [2:0]         phase,
  output logic               step_pulse,
  output logic               winner_valid,
  output logic [1:0]         winner_id
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int STAB_W = $clog2(STABLE_CNT + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_TGT  = STAB_W'(STABLE_CNT);
  localparam logic [POS_W-1:0]  FINISH    = POS_W'(TRACK_LEN);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_ROLL = 3'd1,
    S_CAPTURE   = 3'd2,
    S_MOVE      = 3'd3,
    S_CHECK     = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic               four_q, four_d;        // 1 = four players
  logic               tick_prev_q;
  logic [2:0]         prev_val_q;
  logic [STAB_W-1:0]  stab_q, stab_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [2:0]         rem_q, rem_d;
  logic [POS_W-1:0]   pos_q [4];
  logic [POS_W-1:0]   pos_d [4];
  logic [1:0]         cur_q, cur_d;
  logic [2:0]         roll_q, roll_d;
  logic [1:0]         win_id_q, win_id_d;
`ifdef EXACT_FINISH_EN
  logic               bounce_q, bounce_d;    // finish reached, now walking back
`endif

  logic               legal;
  logic               tick_rise;
  logic [POS_W-1:0]   cur_pos;
  logic [POS_W-1:0]   pos_new;
  logic [STAB_W-1:0]  stab_next;

  always_comb begin
    state_d    = state_q;
    four_d     = four_q;
    stab_d     = stab_q;
    step_d     = step_q;
    rem_d      = rem_q;
    cur_d      = cur_q;
    roll_d     = roll_q;
    win_id_d   = win_id_q;
    pos_d      = pos_q;
    step_pulse = 1'b0;
    pos_new    = '0;
    stab_next  = '0;
`ifdef EXACT_FINISH_EN
    bounce_d   = bounce_q;
`endif
    // "legal" means a reading is present and shows a real face.
    legal      = dice_valid && (dice_value != 3'd0) && (dice_value != 3'd7);
    tick_rise  = game_start_tick && !tick_prev_q;
    cur_pos    = pos_q[cur_q];

    case (state_q)
      S_IDLE: begin
        if (is_game) begin
          four_d  = menu_select;
          state_d = S_WAIT_ROLL;
        end
      end
      S_WAIT_ROLL: begin
        if (tick_rise) begin
          stab_d  = '0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // A run of identical legal readings; any break restarts the run,
        // counting the current reading as its first cycle when legal.
        if (legal && (dice_value == prev_val_q)) stab_next = stab_q + 1'b1;
        else if (legal)                          stab_next = STAB_W'(1);
        else                                     stab_next = '0;
        stab_d = stab_next;
        if (stab_next == STAB_TGT) begin
          roll_d  = dice_value;
          rem_d   = dice_value;
          step_d  = '0;
`ifdef EXACT_FINISH_EN
          bounce_d = 1'b0;
`endif
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        if (step_q == STEP_LAST) begin
          step_pulse = 1'b1;
          step_d     = '0;
          rem_d      = rem_q - 3'd1;
`ifdef EXACT_FINISH_EN
          if (bounce_q) pos_new = cur_pos - POS_W'(1);
          else          pos_new = cur_pos + POS_W'(1);
          if (pos_new == FINISH) bounce_d = 1'b1;
          if (rem_d == 3'd0) state_d = S_CHECK;
`else
          pos_new = cur_pos + POS_W'(1);
          if ((rem_d == 3'd0) || (pos_new == FINISH)) state_d = S_CHECK;
`endif
          pos_d[cur_q] = pos_new;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (cur_pos == FINISH) begin
          win_id_d = cur_q;
          state_d  = S_DONE;
        end else begin
          state_d  = S_NEXT;
        end
      end
      S_NEXT: begin
        if (cur_q == (four_q ? 2'd3 : 2'd1)) cur_d = 2'd0;
        else                                 cur_d = cur_q + 2'd1;
        state_d = S_WAIT_ROLL;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving the game screen aborts everything, even mid-move.
    if (!is_game) begin
      state_d    = S_IDLE;
      cur_d      = 2'd0;
      roll_d     = 3'd0;
      win_id_d   = 2'd0;
      stab_d     = '0;
      step_d     = '0;
      rem_d      = 3'd0;
      step_pulse = 1'b0;
      for (int k = 0; k < 4; k++) pos_d[k] = '0;
`ifdef EXACT_FINISH_EN
      bounce_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      four_q      <= 1'b0;
      tick_prev_q <= 1'b0;
      prev_val_q  <= 3'd0;
      stab_q      <= '0;
      step_q      <= '0;
      rem_q       <= 3'd0;
      cur_q       <= 2'd0;
      roll_q      <= 3'd0;
      win_id_q    <= 2'd0;
      for (int k = 0; k < 4; k++) pos_q[k] <= '0;
`ifdef EXACT_FINISH_EN
      bounce_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      four_q      <= four_d;
      tick_prev_q <= game_start_tick;
      prev_val_q  <= dice_value;
      stab_q      <= stab_d;
      step_q      <= step_d;
      rem_q       <= rem_d;
      cur_q       <= cur_d;
      roll_q      <= roll_d;
      win_id_q    <= win_id_d;
      for (int k = 0; k < 4; k++) pos_q[k] <= pos_d[k];
`ifdef EXACT_FINISH_EN
      bounce_q    <= bounce_d;
`endif
    end
  end

  always_comb begin
    pos_flat = '0;
    for (int k = 0; k < 4; k++) pos_flat[k*POS_W +: POS_W] = pos_q[k];
  end

  assign cur_player   = cur_q;
  assign roll_value   = roll_q;
  assign phase        = state_q;
  assign winner_valid = (state_q == S_DONE);
  assign winner_id    = win_id_q;

endmodule
